// File: rtl/dcache_axi_line_bridge_pkg.sv
// Shared definitions for the D$ line bridge: AXI burst/response encodings,
// the bridge state enum and the line-offset helper.
package dcache_axi_line_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RESP
  } bridge_state_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int unsigned line_offset(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/dcache_axi_line_bridge_if.sv
// AXI4 bus bundle between the line bridge (master) and the interconnect (slave).
interface dcache_axi_line_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast, rid, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready
  );

endinterface

// File: rtl/dcache_axi_line_bridge.sv
// Turns one D$ line refill or writeback into a single AXI4 INCR burst.
// One transaction in flight; the line buffer serves both fill and drain.
module dcache_axi_line_bridge
  import dcache_axi_line_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          LINE_BYTES     = 64,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [LINE_BYTES*8-1:0] req_data_i,

  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [LINE_BYTES*8-1:0] resp_data_o,
  output logic                    resp_err_o,

  dcache_axi_line_bridge_if.master axi
);

  localparam int unsigned BEATS  = LINE_BYTES * 8 / AXI_DATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF    = line_offset(LINE_BYTES);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;
  localparam logic [7:0]            AXI_LEN   = 8'(BEATS - 1);
  localparam logic [2:0]            AXI_SIZE  = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  bridge_state_e                          state_q;
  logic                                   req_ready_q;
  logic                                   resp_valid_q;
  logic                                   arvalid_q;
  logic                                   rready_q;
  logic                                   awvalid_q;
  logic                                   wvalid_q;
  logic                                   bready_q;
  logic                                   err_q;
  logic [ADDR_WIDTH-1:0]                  addr_q;
  logic [BEAT_W-1:0]                      beat_q;
  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0]   line_q;

  logic              last_beat;
  logic [BEAT_W-1:0] beat_d;

  assign last_beat = (beat_q == LAST_BEAT);
  // Saturates so a stray extra beat can never wrap into word 0.
  assign beat_d    = last_beat ? beat_q : beat_q + BEAT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      beat_q       <= '0;
      // NOTE: the line buffer is flops, not a RAM macro, so it is reset and
      // resp_data_o reads zero out of reset.
      line_q       <= '0;
    end else begin
      // NOTE: every assignment here is non-blocking, so each branch sees the
      // pre-edge values of beat_q/line_q regardless of statement order.
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i & LINE_MASK;
            line_q      <= req_data_i;
            err_q       <= 1'b0;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            if (req_we_i) begin
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            line_q[beat_q] <= axi.rdata;
            beat_q         <= beat_d;
            // rlast must coincide exactly with the final beat.
            if (axi.rresp != RESP_OKAY || axi.rlast != last_beat) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (axi.wready) begin
            beat_q <= beat_d;
            if (last_beat) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            if (axi.bresp != RESP_OKAY) begin
              err_q <= 1'b1;
            end
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = line_q;
  assign resp_err_o   = err_q;

  assign axi.arvalid  = arvalid_q;
  assign axi.araddr   = addr_q;
  assign axi.arid     = AXI_ID_WIDTH'(AXI_ID);
  assign axi.arlen    = AXI_LEN;
  assign axi.arsize   = AXI_SIZE;
  assign axi.arburst  = BURST_INCR;
  assign axi.rready   = rready_q;

  assign axi.awvalid  = awvalid_q;
  assign axi.awaddr   = addr_q;
  assign axi.awid     = AXI_ID_WIDTH'(AXI_ID);
  assign axi.awlen    = AXI_LEN;
  assign axi.awsize   = AXI_SIZE;
  assign axi.awburst  = BURST_INCR;

  // Payload comes straight from registers and only moves on a handshake.
  assign axi.wvalid   = wvalid_q;
  assign axi.wdata    = line_q[beat_q];
  assign axi.wstrb    = '1;
  assign axi.wlast    = last_beat;
  assign axi.bready   = bready_q;

endmodule

// File: tb/tb_dcache_axi_line_bridge.sv
// Directed self-checking bench for dcache_axi_line_bridge: refill, writeback,
// error reporting, response back-pressure and reset during a burst.
module tb_dcache_axi_line_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int LB    = 64;
  localparam int BEATS = 16;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [LB*8-1:0] req_data;
  logic            resp_valid, resp_ready, resp_err;
  logic [LB*8-1:0] resp_data;

  dcache_axi_line_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

  dcache_axi_line_bridge #(
    .ADDR_WIDTH(AW), .LINE_BYTES(LB), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_ID(0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .resp_err_o  (resp_err),
    .axi         (axi)
  );

  int vectors = 0;
  int miscompares = 0;

  // Observations filled in by the transaction drivers.
  logic [AW-1:0]   obs_addr;
  logic [7:0]      obs_len;
  logic [2:0]      obs_size;
  logic [1:0]      obs_burst;
  logic [IW-1:0]   obs_id;
  int              obs_addr_cyc, obs_resp_cyc, obs_bready_cyc, obs_bhs_cyc, obs_beats, obs_held;
  logic [LB*8-1:0] obs_resp_data;
  logic            obs_resp_err, obs_timeout, obs_hold_ok, obs_w_early, obs_stall_ok, obs_aborted;
  logic [DW-1:0]   obs_wdata [BEATS];
  logic            obs_wlast [BEATS];

  task automatic idle_slave();
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0;   axi.rid = '0;      axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0;  axi.bresp = 2'b00; axi.bid = '0;
    req_valid = 1'b0;   resp_ready = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr = 'x; obs_len = 'x; obs_size = 'x; obs_burst = 'x; obs_id = 'x;
    obs_addr_cyc = -1; obs_resp_cyc = -1; obs_bready_cyc = -1; obs_bhs_cyc = -1;
    obs_beats = 0; obs_held = 0; obs_resp_err = 1'bx; obs_timeout = 1'b1;
    obs_hold_ok = 1'b1; obs_w_early = 1'b0; obs_stall_ok = 1'b1; obs_aborted = 1'b0;
    for (int i = 0; i < BEATS; i++) begin obs_wdata[i] = 'x; obs_wlast[i] = 1'bx; end
  endtask

  // Response side shared by both drivers: returns 1 once the handshake is set up.
  task automatic resp_side(input int cyc, input int hold, output bit done);
    done = 1'b0;
    if (resp_valid) begin
      if (obs_resp_cyc < 0) begin
        obs_resp_cyc  = cyc;
        obs_resp_data = resp_data;
        obs_resp_err  = resp_err;
        if (req_ready !== 1'b0) obs_hold_ok = 1'b0;
      end else begin
        if (resp_data !== obs_resp_data || resp_err !== obs_resp_err || req_ready !== 1'b0)
          obs_hold_ok = 1'b0;
      end
      resp_ready = (obs_held >= hold);
      if (resp_ready) done = 1'b1;
      else obs_held++;
    end else begin
      resp_ready = 1'b0;
    end
  endtask

  // Zero-wait AR/R slave; rresp=SLVERR on slverr_beat, rlast only on rlast_beat.
  task automatic run_refill(input logic [AW-1:0] addr, input int slverr_beat,
                            input int rlast_beat, input int hold);
    bit ar_done = 1'b0;
    bit done = 1'b0;
    int beat = 0;
    clear_obs();
    @(negedge clk);
    for (int cyc = 0; cyc < LIMIT && !done; cyc++) begin
      req_valid = (cyc == 0); req_we = 1'b0; req_addr = addr;
      req_data  = {BEATS{32'h5555_5555}};
      if (axi.arvalid && !ar_done && obs_addr_cyc < 0) begin
        obs_addr = axi.araddr; obs_len = axi.arlen; obs_size = axi.arsize;
        obs_burst = axi.arburst; obs_id = axi.arid; obs_addr_cyc = cyc;
      end
      axi.arready = 1'b1;
      axi.rvalid  = ar_done && (beat < BEATS);
      axi.rdata   = 32'hA000_0000 + 32'(beat);
      axi.rresp   = (beat == slverr_beat) ? 2'b10 : 2'b00;
      axi.rlast   = axi.rvalid && (beat == rlast_beat);
      if (axi.arvalid && axi.arready) ar_done = 1'b1;
      if (axi.rvalid && axi.rready) beat++;
      resp_side(cyc, hold, done);
      @(negedge clk);
    end
    obs_beats = beat;
    obs_timeout = !done;
    idle_slave();
  endtask

  // AW/W/B slave; wready every cycle or on odd cycles only; optional reset at a W beat.
  task automatic run_writeback(input logic [AW-1:0] addr, input logic [LB*8-1:0] line,
                               input bit toggle, input int abort_beat);
    bit aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0, done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_wdata = '0;
    logic prev_wlast = 1'b0;
    int beat = 0;
    clear_obs();
    @(negedge clk);
    for (int cyc = 0; cyc < LIMIT && !done; cyc++) begin
      req_valid = (cyc == 0); req_we = 1'b1; req_addr = addr; req_data = line;
      if (abort_beat >= 0 && axi.wvalid && beat == abort_beat) begin
        rst_n = 1'b0;
        obs_aborted = 1'b1;
        done = 1'b1;
      end else begin
        if (axi.awvalid && !aw_done && obs_addr_cyc < 0) begin
          obs_addr = axi.awaddr; obs_len = axi.awlen; obs_size = axi.awsize;
          obs_burst = axi.awburst; obs_id = axi.awid; obs_addr_cyc = cyc;
        end
        if (axi.wvalid && !aw_done) obs_w_early = 1'b1;
        if (prev_stall && (!axi.wvalid || axi.wdata !== prev_wdata || axi.wlast !== prev_wlast))
          obs_stall_ok = 1'b0;
        axi.awready = 1'b1;
        axi.wready  = toggle ? (cyc % 2 == 1) : 1'b1;
        axi.bvalid  = w_done && !b_done;
        axi.bresp   = 2'b00;
        if (axi.bready && obs_bready_cyc < 0) obs_bready_cyc = cyc;
        if (axi.awvalid && axi.awready) aw_done = 1'b1;
        prev_stall = axi.wvalid && !axi.wready;
        prev_wdata = axi.wdata;
        prev_wlast = axi.wlast;
        if (axi.wvalid && axi.wready) begin
          if (beat < BEATS) begin obs_wdata[beat] = axi.wdata; obs_wlast[beat] = axi.wlast; end
          beat++;
          if (beat == BEATS) w_done = 1'b1;
        end
        if (axi.bvalid && axi.bready) begin b_done = 1'b1; obs_bhs_cyc = cyc; end
        resp_side(cyc, 0, done);
        @(negedge clk);
      end
    end
    obs_beats = beat;
    obs_timeout = !done;
    idle_slave();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_slave();
    req_we = 1'b0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    vectors++;
    if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_axi_valids got=%b want=00000",
               {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready});
    end
    vectors++; if (axi.araddr !== '0) begin miscompares++; $display("FAIL reset_araddr got=%h want=0", axi.araddr); end
    vectors++; if (resp_data !== '0) begin miscompares++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_refill();
    run_refill(32'h0000_1234, -1, BEATS - 1, 0);
    vectors++; if (obs_timeout !== 1'b0) begin miscompares++; $display("FAIL refill_timeout got=%b want=0", obs_timeout); end
    vectors++; if (obs_addr !== 32'h0000_1200) begin miscompares++; $display("FAIL refill_araddr got=%h want=00001200", obs_addr); end
    vectors++; if (obs_len !== 8'd15) begin miscompares++; $display("FAIL refill_arlen got=%0d want=15", obs_len); end
    vectors++; if (obs_size !== 3'd2) begin miscompares++; $display("FAIL refill_arsize got=%0d want=2", obs_size); end
    vectors++; if (obs_burst !== 2'b01) begin miscompares++; $display("FAIL refill_arburst got=%b want=01", obs_burst); end
    vectors++; if (obs_id !== 4'd0) begin miscompares++; $display("FAIL refill_arid got=%0d want=0", obs_id); end
    vectors++; if (obs_addr_cyc !== 1) begin miscompares++; $display("FAIL refill_arvalid_cycle got=%0d want=1", obs_addr_cyc); end
    vectors++; if (obs_resp_cyc !== 18) begin miscompares++; $display("FAIL refill_resp_cycle got=%0d want=18", obs_resp_cyc); end
    vectors++; if (obs_resp_err !== 1'b0) begin miscompares++; $display("FAIL refill_err got=%b want=0", obs_resp_err); end
    for (int i = 0; i < BEATS; i++) begin
      vectors++;
      if (obs_resp_data[i*DW +: DW] !== 32'hA000_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL refill_word%0d got=%h want=%h", i, obs_resp_data[i*DW +: DW], 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_writeback_throttled();
    logic [LB*8-1:0] line;
    for (int i = 0; i < BEATS; i++) line[i*DW +: DW] = 32'(i);
    run_writeback(32'h8000_0040, line, 1'b1, -1);
    vectors++; if (obs_timeout !== 1'b0) begin miscompares++; $display("FAIL wb_timeout got=%b want=0", obs_timeout); end
    vectors++; if (obs_addr !== 32'h8000_0040) begin miscompares++; $display("FAIL wb_awaddr got=%h want=80000040", obs_addr); end
    vectors++;
    if ({obs_len, obs_size, obs_burst} !== {8'd15, 3'd2, 2'b01}) begin
      miscompares++;
      $display("FAIL wb_aw_fields got=len%0d/size%0d/burst%0d want=len15/size2/burst1", obs_len, obs_size, obs_burst);
    end
    vectors++; if (obs_w_early !== 1'b0) begin miscompares++; $display("FAIL wb_w_before_aw got=%b want=0", obs_w_early); end
    vectors++; if (obs_stall_ok !== 1'b1) begin miscompares++; $display("FAIL wb_w_stall_stable got=%b want=1", obs_stall_ok); end
    vectors++; if (obs_beats !== BEATS) begin miscompares++; $display("FAIL wb_beats got=%0d want=%0d", obs_beats, BEATS); end
    for (int i = 0; i < BEATS; i++) begin
      vectors++;
      if (obs_wdata[i] !== 32'(i) || obs_wlast[i] !== (i == BEATS - 1)) begin
        miscompares++;
        $display("FAIL wb_beat%0d got=%h/last%b want=%h/last%b", i, obs_wdata[i], obs_wlast[i], 32'(i), (i == BEATS - 1));
      end
    end
    vectors++; if (obs_resp_cyc !== obs_bhs_cyc + 1 || obs_bhs_cyc < 0) begin miscompares++; $display("FAIL wb_resp_after_b got=%0d want=%0d", obs_resp_cyc, obs_bhs_cyc + 1); end
    vectors++; if (obs_resp_err !== 1'b0) begin miscompares++; $display("FAIL wb_err got=%b want=0", obs_resp_err); end
  endtask

  task automatic test_refill_slverr();
    run_refill(32'h0000_2000, 5, BEATS - 1, 0);
    vectors++; if (obs_beats !== BEATS) begin miscompares++; $display("FAIL slverr_beats got=%0d want=%0d", obs_beats, BEATS); end
    vectors++; if (obs_resp_cyc !== 18) begin miscompares++; $display("FAIL slverr_resp_cycle got=%0d want=18", obs_resp_cyc); end
    vectors++; if (obs_resp_err !== 1'b1) begin miscompares++; $display("FAIL slverr_err got=%b want=1", obs_resp_err); end
    vectors++; if (obs_resp_data[15*DW +: DW] !== 32'hA000_000F) begin miscompares++; $display("FAIL slverr_word15 got=%h want=a000000f", obs_resp_data[15*DW +: DW]); end
  endtask

  task automatic test_refill_early_rlast();
    run_refill(32'h0000_3000, -1, BEATS - 2, 0);
    vectors++; if (obs_beats !== BEATS) begin miscompares++; $display("FAIL rlast_beats got=%0d want=%0d", obs_beats, BEATS); end
    vectors++; if (obs_resp_cyc !== 18) begin miscompares++; $display("FAIL rlast_resp_cycle got=%0d want=18", obs_resp_cyc); end
    vectors++; if (obs_resp_err !== 1'b1) begin miscompares++; $display("FAIL rlast_err got=%b want=1", obs_resp_err); end
  endtask

  task automatic test_resp_backpressure();
    run_refill(32'h0000_4040, -1, BEATS - 1, 5);
    vectors++; if (obs_timeout !== 1'b0) begin miscompares++; $display("FAIL hold_timeout got=%b want=0", obs_timeout); end
    vectors++; if (obs_held !== 5) begin miscompares++; $display("FAIL hold_cycles got=%0d want=5", obs_held); end
    vectors++; if (obs_hold_ok !== 1'b1) begin miscompares++; $display("FAIL hold_stable got=%b want=1", obs_hold_ok); end
    vectors++; if (obs_resp_data[3*DW +: DW] !== 32'hA000_0003) begin miscompares++; $display("FAIL hold_word3 got=%h want=a0000003", obs_resp_data[3*DW +: DW]); end
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release got=valid%b/ready%b want=valid0/ready1", resp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_writeback();
    logic [LB*8-1:0] line;
    for (int i = 0; i < BEATS; i++) line[i*DW +: DW] = 32'h1111_1111 * 32'(i);
    run_writeback(32'h8000_0100, line, 1'b0, 7);
    vectors++; if (obs_aborted !== 1'b1) begin miscompares++; $display("FAIL rst_reached_beat7 got=%b want=1", obs_aborted); end
    #1;
    vectors++;
    if ({axi.wvalid, axi.awvalid, axi.bready, resp_valid} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_drop got=%b want=0000", {axi.wvalid, axi.awvalid, axi.bready, resp_valid});
    end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BEATS; i++) line[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    run_writeback(32'h8000_01A4, line, 1'b0, -1);
    vectors++; if (obs_addr !== 32'h8000_0180) begin miscompares++; $display("FAIL post_rst_awaddr got=%h want=80000180", obs_addr); end
    vectors++; if (obs_addr_cyc !== 1) begin miscompares++; $display("FAIL post_rst_awvalid_cycle got=%0d want=1", obs_addr_cyc); end
    vectors++; if (obs_bready_cyc !== 18) begin miscompares++; $display("FAIL post_rst_bready_cycle got=%0d want=18", obs_bready_cyc); end
    vectors++; if (obs_resp_cyc !== 19) begin miscompares++; $display("FAIL post_rst_resp_cycle got=%0d want=19", obs_resp_cyc); end
    vectors++; if (obs_beats !== BEATS) begin miscompares++; $display("FAIL post_rst_beats got=%0d want=%0d", obs_beats, BEATS); end
    for (int i = 0; i < BEATS; i++) begin
      vectors++;
      if (obs_wdata[i] !== 32'hC0DE_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL post_rst_beat%0d got=%h want=%h", i, obs_wdata[i], 32'hC0DE_0000 + 32'(i));
      end
    end
    vectors++; if (obs_resp_err !== 1'b0) begin miscompares++; $display("FAIL post_rst_err got=%b want=0", obs_resp_err); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_writeback_throttled();
    test_refill_slverr();
    test_refill_early_rlast();
    test_resp_backpressure();
    test_reset_mid_writeback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
